// File: rtl/line_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : line_burst_adaptor
// Description : Responder for single-line L2 read/write requests. Each request
//               becomes a BEATS x BEAT_WIDTH burst on physical memory and is
//               answered with a one-cycle resp_o pulse. An optional watchdog,
//               enabled by defining LINE_BURST_ADAPTOR_TIMEOUT_EN, aborts a
//               stalled burst after TIMEOUT_CYCLES and raises a sticky error_o.
// Revision    : 1.0 - initial release
// ============================================================================
module line_burst_adaptor #(
    parameter int ADDR_WIDTH     = 27,
    parameter int BEAT_WIDTH     = 64,
    parameter int BEATS          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       address_i,
    input  logic                        read_i,
    input  logic                        write_i,
    input  logic [BEATS*BEAT_WIDTH-1:0] line_i,
    output logic [BEATS*BEAT_WIDTH-1:0] line_o,
    output logic                        resp_o,
    output logic [31:0]                 pmem_address_o,
    output logic                        pmem_read_o,
    output logic                        pmem_write_o,
    output logic [BEAT_WIDTH-1:0]       burst_o,
    input  logic [BEAT_WIDTH-1:0]       burst_i,
    input  logic                        pmem_resp_i,
    output logic                        error_o
);

    localparam int c_LINE_W = BEATS * BEAT_WIDTH;
    localparam int c_CNT_W  = $clog2(BEATS);
    localparam int c_OFS_W  = 32 - ADDR_WIDTH;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_READ  = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;

    logic [2:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_LINE_W-1:0]   r_buf;      // write line being sent, or read line being assembled
    logic [c_LINE_W-1:0]   w_assembled;
    logic [c_CNT_W-1:0]    w_cnt_next;
    logic [BEAT_WIDTH-1:0] w_next_beat;
    logic                  w_last;
    logic                  w_timeout;

    // Beat bookkeeping: buffer with the current beat merged in, next slot, last-beat flag
    always_comb begin
        w_assembled = r_buf;
        w_assembled[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] = burst_i;
        w_cnt_next  = r_cnt + 1'b1;
        w_next_beat = r_buf[w_cnt_next*BEAT_WIDTH +: BEAT_WIDTH];
        w_last      = (r_cnt == c_CNT_W'(BEATS - 1));
    end

`ifdef LINE_BURST_ADAPTOR_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd;
    logic              r_error;
    logic              w_busy;

    assign w_busy    = (r_state == c_ST_READ) || (r_state == c_ST_WRITE);
    assign w_timeout = (r_wd == c_WD_W'(TIMEOUT_CYCLES - 1));
    assign error_o   = r_error;

    // Watchdog: counts stalled burst cycles; cleared outside bursts and on every beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd    <= '0;
            r_error <= 1'b0;
        end else begin
            if (!w_busy || pmem_resp_i) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_busy && !pmem_resp_i && w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end
`else
    // Watchdog absent: a stalled burst waits forever and error_o never rises
    assign w_timeout = 1'b0;
    assign error_o   = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // Request/burst sequencer: IDLE -> READ|WRITE -> DONE (resp pulse) -> HOLD -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_buf          <= '0;
            line_o         <= '0;
            resp_o         <= 1'b0;
            pmem_address_o <= '0;
            pmem_read_o    <= 1'b0;
            pmem_write_o   <= 1'b0;
            burst_o        <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    // Write has priority; a simultaneous read is dropped and must be re-requested
                    if (write_i) begin
                        pmem_address_o <= {address_i, {c_OFS_W{1'b0}}};
                        r_buf          <= line_i;
                        burst_o        <= line_i[BEAT_WIDTH-1:0];
                        pmem_write_o   <= 1'b1;
                        r_state        <= c_ST_WRITE;
                    end else if (read_i) begin
                        pmem_address_o <= {address_i, {c_OFS_W{1'b0}}};
                        pmem_read_o    <= 1'b1;
                        r_state        <= c_ST_READ;
                    end
                end
                c_ST_READ: begin
                    if (pmem_resp_i) begin
                        r_buf <= w_assembled;
                        r_cnt <= w_cnt_next;
                        if (w_last) begin
                            line_o      <= w_assembled;
                            pmem_read_o <= 1'b0;
                            resp_o      <= 1'b1;
                            r_state     <= c_ST_DONE;
                        end
                    end else if (w_timeout) begin
                        // Abandon the burst; line_o keeps the last good line
                        r_cnt       <= '0;
                        pmem_read_o <= 1'b0;
                        resp_o      <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_WRITE: begin
                    if (pmem_resp_i) begin
                        r_cnt   <= w_cnt_next;
                        burst_o <= w_next_beat;
                        if (w_last) begin
                            pmem_write_o <= 1'b0;
                            resp_o       <= 1'b1;
                            r_state      <= c_ST_DONE;
                        end
                    end else if (w_timeout) begin
                        r_cnt        <= '0;
                        pmem_write_o <= 1'b0;
                        resp_o       <= 1'b1;
                        r_state      <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    resp_o  <= 1'b0;
                    r_state <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    // Gap cycle so a level request can be withdrawn before IDLE samples it
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
